// File: rtl/nes_clk_reset_gen.sv
// rtl/nes_clk_reset_gen.sv - PLL lock qualification, system reset and NES clock enables.
// Everything runs on the master clock; CPU/PPU/M2 timing is expressed as enables and levels.
module nes_clk_reset_gen #(
    parameter int LOCK_HOLD = 1024,
    parameter int CPU_DIV   = 12,
    parameter int PPU_DIV   = 4,
    parameter int M2_LOW    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    output logic       sys_rst_n,
    output logic       cpu_ce,
    output logic       ppu_ce,
    output logic       m2,
    output logic       running,
    output logic [7:0] lock_loss_cnt
);

    localparam int HW = $clog2(LOCK_HOLD);
    localparam int DW = $clog2(CPU_DIV);
    localparam int PW = $clog2(PPU_DIV);

    localparam logic [HW-1:0] HOLD_LAST = HW'(LOCK_HOLD - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CPU_DIV - 1);
    localparam logic [PW-1:0] PPU_LAST  = PW'(PPU_DIV - 1);
    localparam logic [DW-1:0] M2_START  = DW'(M2_LOW);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d;
    logic          lk_q, lk_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [PW-1:0] ppu_cnt_q, ppu_cnt_d;
    logic [7:0]    loss_q, loss_d;
    logic          sys_rst_n_q, sys_rst_n_d;
    logic          running_q, running_d;
    logic          run_next;

    always_comb begin
        sync1_d    = pll_locked;
        lk_d       = sync1_q;
        state_d    = state_q;
        hold_cnt_d = '0;
        loss_d     = loss_q;

        case (state_q)
            WAIT_LOCK: begin
                if (lk_q) state_d = HOLD;
            end
            HOLD: begin
                if (!lk_q) begin
                    state_d = WAIT_LOCK;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!lk_q) begin
                    state_d = WAIT_LOCK;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase

        // Counters only advance while staying in RUN, so every RUN entry starts phase 0.
        run_next  = (state_d == RUN);
        div_cnt_d = '0;
        ppu_cnt_d = '0;
        if (state_q == RUN && run_next) begin
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
            ppu_cnt_d = (ppu_cnt_q == PPU_LAST) ? '0 : ppu_cnt_q + 1'b1;
        end

        sys_rst_n_d = run_next;
        running_d   = run_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            lk_q        <= 1'b0;
            state_q     <= WAIT_LOCK;
            hold_cnt_q  <= '0;
            div_cnt_q   <= '0;
            ppu_cnt_q   <= '0;
            loss_q      <= 8'd0;
            sys_rst_n_q <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            lk_q        <= lk_d;
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            div_cnt_q   <= div_cnt_d;
            ppu_cnt_q   <= ppu_cnt_d;
            loss_q      <= loss_d;
            sys_rst_n_q <= sys_rst_n_d;
            running_q   <= running_d;
        end
    end

    assign sys_rst_n     = sys_rst_n_q;
    assign running       = running_q;
    assign lock_loss_cnt = loss_q;
    assign cpu_ce        = (state_q == RUN) && (div_cnt_q == DIV_LAST);
    assign ppu_ce        = (state_q == RUN) && (ppu_cnt_q == PPU_LAST);
    assign m2            = (state_q == RUN) && (div_cnt_q >= M2_START);

endmodule

// File: tb/tb_nes_clk_reset_gen.sv
// tb/tb_nes_clk_reset_gen.sv - self-checking bench for nes_clk_reset_gen.
module tb_nes_clk_reset_gen;

    logic       clk = 1'b0;
    logic       rst_n_a, pll_a, rst_n_b, pll_b;
    logic       sys_a, cpu_a, ppu_a, m2_a, run_a;
    logic       sys_b, cpu_b, ppu_b, m2_b, run_b;
    logic [7:0] loss_a, loss_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nes_clk_reset_gen u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .pll_locked(pll_a),
        .sys_rst_n(sys_a), .cpu_ce(cpu_a), .ppu_ce(ppu_a), .m2(m2_a),
        .running(run_a), .lock_loss_cnt(loss_a)
    );

    nes_clk_reset_gen #(.LOCK_HOLD(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .pll_locked(pll_b),
        .sys_rst_n(sys_b), .cpu_ce(cpu_b), .ppu_ce(ppu_b), .m2(m2_b),
        .running(run_b), .lock_loss_cnt(loss_b)
    );

    typedef struct {
        logic       rst_n;
        logic       pll;
        int         ticks;
        logic       exp_sys;
        logic       exp_run;
        logic [7:0] exp_loss;
    } vec_t;

    typedef struct {
        logic       sys;
        logic       run;
        logic [7:0] loss;
    } ctl_exp_t;

    vec_t       vecs[10];
    ctl_exp_t   ctl_q[$];
    logic [2:0] ce_q[$];

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [2:0] ce_model(input int idx);
        ce_model = {(idx % 12) == 11, (idx % 4) == 3, (idx % 12) >= 5};
    endfunction

    task automatic run_window_a(input int ncyc, input string tag,
                                output int n_cpu, output int n_ppu, output int n_m2, output int bad_align);
        logic [2:0] e;
        n_cpu = 0; n_ppu = 0; n_m2 = 0; bad_align = 0;
        for (int i = 0; i < ncyc; i++) begin
            ce_q.push_back(ce_model(i));
            e = ce_q.pop_front();
            chk(tag, {29'd0, cpu_a, ppu_a, m2_a}, {29'd0, e});
            n_cpu += int'(cpu_a);
            n_ppu += int'(ppu_a);
            n_m2  += int'(m2_a);
            if (cpu_a && !ppu_a) bad_align++;
            tick(1);
        end
    endtask

    initial begin
        int n_cpu, n_ppu, n_m2, bad_align, extra, bad_relock, found;
        ctl_exp_t e;

        vecs[0] = '{1'b0, 1'b0, 2,  1'b0, 1'b0, 8'd0};
        vecs[1] = '{1'b1, 1'b0, 4,  1'b0, 1'b0, 8'd0};
        vecs[2] = '{1'b1, 1'b1, 11, 1'b0, 1'b0, 8'd0};
        vecs[3] = '{1'b1, 1'b0, 1,  1'b0, 1'b0, 8'd0};
        vecs[4] = '{1'b1, 1'b1, 18, 1'b0, 1'b0, 8'd0};
        vecs[5] = '{1'b1, 1'b1, 1,  1'b1, 1'b1, 8'd0};
        vecs[6] = '{1'b1, 1'b0, 2,  1'b1, 1'b1, 8'd0};
        vecs[7] = '{1'b1, 1'b0, 1,  1'b0, 1'b0, 8'd1};
        vecs[8] = '{1'b1, 1'b1, 18, 1'b0, 1'b0, 8'd1};
        vecs[9] = '{1'b1, 1'b1, 1,  1'b1, 1'b1, 8'd1};

        rst_n_a = 1'b1; pll_a = 1'b1;
        rst_n_b = 1'b1; pll_b = 1'b0;
        #2;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        #1;
        chk("reset_sys_rst_n", sys_a, 0);
        chk("reset_enables", {cpu_a, ppu_a, m2_a, run_a}, 0);
        chk("reset_loss", loss_a, 0);

        // Full 1024-cycle qualification from reset release.
        tick(3);
        rst_n_a = 1'b1;
        tick(1026);
        chk("release_not_early", sys_a, 0);
        tick(1);
        chk("release_at_1027", {sys_a, run_a}, 2'b11);

        run_window_a(240, "ce_pattern", n_cpu, n_ppu, n_m2, bad_align);
        chk("cpu_ce_count_240", n_cpu, 20);
        chk("ppu_ce_count_240", n_ppu, 60);
        chk("m2_high_count_240", n_m2, 140);
        chk("cpu_without_ppu", bad_align, 0);

        // Lock loss at div_cnt 7: window above ended on a phase-0 cycle.
        tick(7);
        pll_a = 1'b0;
        tick(2);
        chk("loss_still_running", {sys_a, run_a, m2_a}, 3'b111);
        tick(1);
        chk("loss_drop_3_edges", {sys_a, run_a, m2_a, cpu_a, ppu_a}, 0);
        chk("loss_count_1", loss_a, 1);
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            if (cpu_a || ppu_a || m2_a) extra++;
            tick(1);
        end
        chk("no_ce_after_loss", extra, 0);
        pll_a = 1'b1;
        tick(1026);
        chk("relock_not_early", sys_a, 0);
        tick(1);
        chk("relock_run", sys_a, 1);
        run_window_a(24, "relock_pattern", n_cpu, n_ppu, n_m2, bad_align);
        chk("relock_cpu_count", n_cpu, 2);

        // LOCK_HOLD=16 instance: table with a glitch at hold count 10.
        for (int v = 0; v < 10; v++) begin
            rst_n_b = vecs[v].rst_n;
            pll_b   = vecs[v].pll;
            ctl_q.push_back('{vecs[v].exp_sys, vecs[v].exp_run, vecs[v].exp_loss});
            tick(vecs[v].ticks);
            e = ctl_q.pop_front();
            chk($sformatf("vec%0d_sys_rst_n", v), sys_b, e.sys);
            chk($sformatf("vec%0d_running", v), run_b, e.run);
            chk($sformatf("vec%0d_loss", v), loss_b, e.loss);
        end

        // Saturation of the lock-loss counter.
        bad_relock = 0;
        for (int j = 1; j <= 300; j++) begin
            pll_b = 1'b0;
            tick(3);
            if (run_b) bad_relock++;
            pll_b = 1'b1;
            tick(19);
            if (!run_b) bad_relock++;
            if (j == 253) chk("loss_254", loss_b, 254);
        end
        chk("relock_each_iter", bad_relock, 0);
        chk("loss_saturated", loss_b, 255);

        pll_b = 1'b0;
        tick(3);
        pll_b = 1'b1;
        tick(8);
        chk("mid_hold_loss_kept", loss_b, 255);
        #2;
        rst_n_b = 1'b0;
        #1;
        chk("async_rst_loss", loss_b, 0);
        chk("async_rst_outputs", {sys_b, run_b, cpu_b, ppu_b, m2_b}, 0);

        // Async reset from RUN while cpu_ce is high.
        found = 0;
        for (int i = 0; i < 12 && found == 0; i++) begin
            if (cpu_a) found = 1;
            else tick(1);
        end
        chk("found_cpu_ce", found, 1);
        #2;
        rst_n_a = 1'b0;
        #1;
        chk("async_rst_run_outputs", {sys_a, run_a, cpu_a, ppu_a, m2_a}, 0);
        chk("async_rst_run_loss", loss_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
